// File: rtl/packer_pkg.sv
// Shared widths and the FIFO entry layout for the byte-to-word packer.
package packer_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BYTES_PER_WORD = 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic [3:0]        bytes;
    } word_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO using extra-bit pointers for full/empty detection.
// The read port is registered; rd_valid pulses for one cycle per word popped.
module fifo_sync #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
            r_rd_valid <= w_pop;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: rtl/packer_8_64.sv
// Packs a strobed byte stream MSB-first into 64-bit words and queues them
// with a last-of-line flag and valid-byte count for a request-driven reader.
module packer_8_64
    import packer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe_in,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_end_in,
    output logic              ready,
    input  logic              req_data,
    output logic              strobe_out,
    output logic [WORD_W-1:0] data_out,
    output logic              data_last,
    output logic [3:0]        data_bytes,
    output logic              empty,
    output logic              drop_err
);

    logic [WORD_W-1:0] r_shift;
    logic [2:0]        r_byte_cnt;
    logic              r_drop_err;

    logic              w_full;
    logic              w_accept;
    logic              w_complete;
    logic [WORD_W-1:0] w_word;
    word_entry_t       w_wr_entry;
    word_entry_t       w_rd_entry;

    assign ready      = !w_full;
    assign w_accept   = strobe_in && !w_full;
    assign w_complete = w_accept && ((r_byte_cnt == 3'(BYTES_PER_WORD - 1)) || data_end_in);

    // Lane 0 is the top byte; shifting right by 8*byte_cnt places the new byte.
    assign w_word = r_shift | ({data_in, {(WORD_W-BYTE_W){1'b0}}} >> {r_byte_cnt, 3'b000});

    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.data  = w_word;
        w_wr_entry.last  = data_end_in;
        w_wr_entry.bytes = {1'b0, r_byte_cnt} + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= strobe_in && w_full;
            if (w_accept) begin
                if (w_complete) begin
                    r_shift    <= '0;
                    r_byte_cnt <= '0;
                end else begin
                    r_shift    <= w_word;
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
            end
        end
    end

    fifo_sync #(
        .WIDTH($bits(word_entry_t)),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_complete),
        .wr_data (w_wr_entry),
        .full    (w_full),
        .rd_en   (req_data),
        .rd_valid(strobe_out),
        .rd_data (w_rd_entry),
        .empty   (empty)
    );

    assign data_out   = w_rd_entry.data;
    assign data_last  = w_rd_entry.last;
    assign data_bytes = w_rd_entry.bytes;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_packer_8_64.sv
// Self-checking bench for packer_8_64 against a queue-based behavioural model.
module tb_packer_8_64;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [3:0]  bytes;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe_in;
    logic [7:0]  data_in;
    logic        data_end_in;
    logic        ready;
    logic        req_data;
    logic        strobe_out;
    logic [63:0] data_out;
    logic        data_last;
    logic [3:0]  data_bytes;
    logic        empty;
    logic        drop_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    ent_t        mq[$];
    logic [7:0]  part[$];
    ent_t        m_out;
    logic        m_strobe;
    logic        m_drop;

    packer_8_64 #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe_in  (strobe_in),
        .data_in    (data_in),
        .data_end_in(data_end_in),
        .ready      (ready),
        .req_data   (req_data),
        .strobe_out (strobe_out),
        .data_out   (data_out),
        .data_last  (data_last),
        .data_bytes (data_bytes),
        .empty      (empty),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    // Drives one cycle, advances the model, and returns #1 after the edge.
    task automatic cycle(input logic s, input logic [7:0] d, input logic e, input logic rq);
        ent_t ent;
        logic can_take;
        strobe_in   = s;
        data_in     = d;
        data_end_in = e;
        req_data    = rq;
        can_take    = (mq.size() < DEPTH);
        m_strobe    = rq && (mq.size() != 0);
        if (m_strobe) m_out = mq.pop_front();
        m_drop = s && !can_take;
        if (s && can_take) begin
            part.push_back(d);
            if (part.size() == 8 || e) begin
                ent.data = '0;
                for (int i = 0; i < part.size(); i++) ent.data[63-8*i -: 8] = part[i];
                ent.last  = e;
                ent.bytes = 4'(part.size());
                mq.push_back(ent);
                part.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        strobe_in = 1'b0; data_in = '0; data_end_in = 1'b0; req_data = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        part.delete();
        m_out = '0;
        m_strobe = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (strobe_out !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", strobe_out); end
        checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
        checks++; if (data_last !== 1'b0 || data_bytes !== 4'd0) begin errors++; $display("FAIL reset_meta: got last=%b bytes=%0d expected 0/0", data_last, data_bytes); end
        checks++; if (empty !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL reset_flags: got empty=%b ready=%b expected 1/1", empty, ready); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_err); end
    endtask

    task automatic test_full_word_end();
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), (i == 8), 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (strobe_out !== 1'b1) begin errors++; $display("FAIL t1_strobe: got %b expected 1", strobe_out); end
        checks++; if (data_out !== 64'h0102030405060708 || data_out !== m_out.data) begin errors++; $display("FAIL t1_data: got %h expected %h", data_out, 64'h0102030405060708); end
        checks++; if (data_last !== 1'b1 || data_bytes !== 4'd8) begin errors++; $display("FAIL t1_meta: got last=%b bytes=%0d expected 1/8", data_last, data_bytes); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (strobe_out !== 1'b0 || data_out !== 64'h0102030405060708) begin errors++; $display("FAIL t1_hold: got strobe=%b data=%h expected 0/%h", strobe_out, data_out, 64'h0102030405060708); end
    endtask

    task automatic test_partial_word();
        do_reset();
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 8'h55, 1'b1, 1'b0);   // end without strobe is ignored
        cycle(1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (strobe_out !== 1'b1 || data_out !== 64'hAABBCC0000000000) begin errors++; $display("FAIL t2_data: got strobe=%b data=%h expected 1/%h", strobe_out, data_out, 64'hAABBCC0000000000); end
        checks++; if (data_last !== 1'b1 || data_bytes !== 4'd3) begin errors++; $display("FAIL t2_meta: got last=%b bytes=%0d expected 1/3", data_last, data_bytes); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t2_empty: got %b expected 1", empty); end
    endtask

    task automatic test_stream_no_end();
        logic [63:0] exp_w [2];
        exp_w[0] = 64'h0001020304050607;
        exp_w[1] = 64'h08090A0B0C0D0E0F;
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (k < 2) begin
                checks++; if (strobe_out !== 1'b1 || data_out !== exp_w[k]) begin errors++; $display("FAIL t3_word%0d: got strobe=%b data=%h expected 1/%h", k, strobe_out, data_out, exp_w[k]); end
                checks++; if (data_last !== 1'b0 || data_bytes !== 4'd8) begin errors++; $display("FAIL t3_meta%0d: got last=%b bytes=%0d expected 0/8", k, data_last, data_bytes); end
            end else begin
                checks++; if (strobe_out !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL t3_drain: got strobe=%b empty=%b expected 0/1", strobe_out, empty); end
            end
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (ready !== 1'b0 || mq.size() != DEPTH) begin errors++; $display("FAIL t4_full: got ready=%b expected 0", ready); end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (drop_err !== 1'b1 || drop_err !== m_drop) begin errors++; $display("FAIL t4_drop: got %b expected 1", drop_err); end
        // Pop on the same cycle as a strobe into a full FIFO must not save the byte.
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL t4_drop_pop: got %b expected 1", drop_err); end
        checks++; if (strobe_out !== 1'b1 || data_out !== 64'h0001020304050607) begin errors++; $display("FAIL t4_oldest: got strobe=%b data=%h expected 1/%h", strobe_out, data_out, 64'h0001020304050607); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t4_ready: got %b expected 1", ready); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL t4_drop_clear: got %b expected 0", drop_err); end
        for (int k = 0; k < DEPTH - 1; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            checks++; if (strobe_out !== 1'b1 || data_out !== m_out.data) begin errors++; $display("FAIL t4_drain%0d: got strobe=%b data=%h expected 1/%h", k, strobe_out, data_out, m_out.data); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t4_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_midline();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h21 + 8'(i), (i == 7), 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (strobe_out !== 1'b1 || data_out !== 64'h2122232425262728) begin errors++; $display("FAIL t5_data: got strobe=%b data=%h expected 1/%h", strobe_out, data_out, 64'h2122232425262728); end
        checks++; if (data_last !== 1'b1 || data_bytes !== 4'd8) begin errors++; $display("FAIL t5_meta: got last=%b bytes=%0d expected 1/8", data_last, data_bytes); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (strobe_out !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL t5_stale: got strobe=%b empty=%b expected 0/1", strobe_out, empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            cycle(1'b1, 8'($urandom), ($urandom_range(0, 99) < 10), 1'b1);
            checks++; if (strobe_out !== m_strobe || data_out !== m_out.data || data_last !== m_out.last || data_bytes !== m_out.bytes) begin errors++; $display("FAIL b2b_out c=%0d: got %b/%h/%b/%0d expected %b/%h/%b/%0d", c, strobe_out, data_out, data_last, data_bytes, m_strobe, m_out.data, m_out.last, m_out.bytes); end
            checks++; if (drop_err !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_flow c=%0d: got drop=%b ready=%b expected 0/1", c, drop_err, ready); end
            checks++; if (empty !== (mq.size() == 0) || mq.size() > 1) begin errors++; $display("FAIL b2b_empty c=%0d: got %b expected %b", c, empty, (mq.size() == 0)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            cycle(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 20 : 80)));
            checks++; if (strobe_out !== m_strobe || data_out !== m_out.data || data_last !== m_out.last || data_bytes !== m_out.bytes) begin errors++; $display("FAIL rnd_out c=%0d: got %b/%h/%b/%0d expected %b/%h/%b/%0d", c, strobe_out, data_out, data_last, data_bytes, m_strobe, m_out.data, m_out.last, m_out.bytes); end
            checks++; if (drop_err !== m_drop) begin errors++; $display("FAIL rnd_drop c=%0d: got %b expected %b", c, drop_err, m_drop); end
            checks++; if (empty !== (mq.size() == 0) || ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_flags c=%0d: got empty=%b ready=%b expected %b/%b", c, empty, ready, (mq.size() == 0), (mq.size() < DEPTH)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        strobe_in = 1'b0; data_in = '0; data_end_in = 1'b0; req_data = 1'b0;
        test_reset();
        test_full_word_end();
        test_partial_word();
        test_stream_no_end();
        test_full_drop();
        test_reset_midline();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packer_8_64.md
Name: packer_8_64

Overview:
Byte-to-word assembler, the receive-side counterpart of the 64-to-8 serializer. It accepts an 8-bit byte stream with a strobe and an end-of-line marker, and packs the bytes MSB-first into 64-bit words. Completed words are buffered in a synchronous FIFO. A downstream consumer reads them one per request, each with a last-word flag and a valid-byte count.

Parameters:
DEPTH, 8, FIFO depth in words; power of 2, at least 2.
AW, $clog2(DEPTH), FIFO address width. Pointers are AW+1 bits.

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
strobe_in  in  1  data_in is valid this cycle
data_in  in  8  input byte
data_end_in  in  1  qualifies strobe_in; marks this byte as the last of a line
ready  out  1  FIFO not full; upstream may strobe
req_data  in  1  request for one word from the consumer
strobe_out  out  1  data_out, data_last and data_bytes are valid (one-cycle pulse per word)
data_out  out  64  assembled word
data_last  out  1  this word ends a line
data_bytes  out  4  valid bytes in the word, 1..8, left-aligned
empty  out  1  FIFO holds no words
drop_err  out  1  one-cycle pulse: a strobed byte was rejected

Behaviour:
- Reset values (when reset=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, byte_cnt=0, shift register=0.
  - strobe_out=0, data_out=0, data_last=0, data_bytes=0, drop_err=0.
  - After reset, empty=1 and ready=1.
- Reset mid-line discards the partial word and all FIFO contents. No word is emitted for the partial line.
- full = (wr_ptr[AW-1:0]==rd_ptr[AW-1:0]) && (wr_ptr[AW]!=rd_ptr[AW]); empty = (wr_ptr==rd_ptr).
- ready = !full, combinational from registered pointers.
- Byte accept, when strobe_in && ready:
  - byte goes into lane byte_cnt; byte 0 occupies [63:56], byte 7 occupies [7:0].
  - byte_cnt increments.
- Word complete, when an accepted byte has byte_cnt==7 OR data_end_in=1:
  - FIFO entry {word, last=data_end_in, bytes=byte_cnt+1} is written the same edge.
  - Unfilled lanes are written as 0.
  - byte_cnt and the shift register return to 0.
- A complete 8-byte word with data_end_in=1 gives last=1, bytes=8.
- data_end_in without strobe_in is ignored.
- Reject: strobe_in && !ready → byte dropped, byte_cnt unchanged, drop_err=1 next cycle.
  - full is evaluated from pre-edge pointers, so a pop on the same cycle does not rescue the byte.
- Read: req_data && !empty at edge N:
  - rd_ptr increments.
  - At N+1: strobe_out=1 and data_out/data_last/data_bytes hold the entry. Latency is one cycle; outputs are registered.
  - req_data held high streams one word per cycle until empty.
  - req_data while empty is ignored; strobe_out=0.
  - data_out/data_last/data_bytes keep their last value when strobe_out=0.
- Simultaneous push and pop in one cycle are both performed; occupancy is unchanged.
- Pointer wrap is natural modulo 2^(AW+1).
- The accept path holds no more than one partial word. A partial word blocked by full is not an error; bytes are only rejected at the strobe.

Decomposition:
- Package packer_pkg:
  - constants BYTE_W=8, WORD_W=64, BYTES_PER_WORD=8.
  - typedef struct packed {logic [WORD_W-1:0] data; logic last; logic [3:0] bytes;} word_entry_t (69 bits).
- Sub-module fifo_sync (WIDTH, DEPTH):
  - extra-bit pointers, full/empty, registered read output.
- Top-level owns the byte assembler and drop_err; it instantiates fifo_sync with WIDTH=$bits(word_entry_t).

Test Plan:
1. Bytes 01..08, data_end_in on 08, then req_data pulse → next cycle strobe_out=1, data_out=0x0102030405060708, data_last=1, data_bytes=8.
2. Bytes AA,BB,CC, data_end_in on CC, then req → data_out=0xAABBCC0000000000, data_last=1, data_bytes=3.
3. 16 bytes 00..0F, no data_end_in, then req held 3 cycles → two strobes: 0x0001020304050607 and 0x08090A0B0C0D0E0F, both data_last=0 and bytes=8; third cycle strobe_out=0 and empty=1.
4. Push 8 full words with DEPTH=8 and no req → ready=0. Next strobe → drop_err pulses, no write. One req → ready=1 the following cycle. The first word read is the oldest.
5. 5 bytes 11..15, then reset for 1 cycle, then 8 bytes 21..28 with end → single word 0x2122232425262728, bytes=8; no stale data.
6. Continuous strobe_in with req_data held high → empty never exceeds 1 cycle of occupancy, every byte appears exactly once in order, no drop_err.
